// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the keypad scanner and the lock FSM that consumes its key codes.
// Key code layout is {row_idx[1:0], col_idx[1:0]}.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  localparam logic [3:0] ROW_IDLE  = 4'b1111;
  localparam logic [3:0] COL_NONE  = 4'b1111;
  localparam logic [3:0] ROW_FIRST = 4'b1110;

  // Digit values the lock FSM compares against; letters keep their hex value.
  localparam logic [3:0] DIGIT_STAR = 4'hE;
  localparam logic [3:0] DIGIT_HASH = 4'hF;

  function automatic logic [3:0] key_digit(input logic [3:0] code);
    logic [3:0] dig;
    case (code)
      4'd0:    dig = 4'd1;
      4'd1:    dig = 4'd2;
      4'd2:    dig = 4'd3;
      4'd3:    dig = 4'hA;
      4'd4:    dig = 4'd4;
      4'd5:    dig = 4'd5;
      4'd6:    dig = 4'd6;
      4'd7:    dig = 4'hB;
      4'd8:    dig = 4'd7;
      4'd9:    dig = 4'd8;
      4'd10:   dig = 4'd9;
      4'd11:   dig = 4'hC;
      4'd12:   dig = DIGIT_STAR;
      4'd13:   dig = 4'd0;
      4'd14:   dig = DIGIT_HASH;
      default: dig = 4'hD;
    endcase
    return dig;
  endfunction

  // Exactly one column pulled low; anything else is ghosting, multi-key or idle.
  function automatic logic single_low(input logic [3:0] pat);
    logic ok;
    case (pat)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] pat);
    logic [1:0] idx;
    case (pat)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running scan-rate divider: one-clk tick every SCAN_DIV clocks.
// Shared with the display row driver so both scan at the same rate.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 62500
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    if (tick) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row rotation, column synchronisation, press/release debounce, key events.
// Optional auto-repeat while held is built when KEYPAD_REPEAT_EN is defined.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 62500,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 2) begin : g_bad_cfg
    $error("keypad_scan: DEBOUNCE_SCANS must be 2..15 and REPEAT_SCANS at least 2");
  end

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

  logic       tick;
  logic [3:0] col_meta_q;
  logic [3:0] col_sync_q;

  kp_state_e  state_q;
  logic [3:0] row_q;
  logic [1:0] row_idx_q;
  logic [3:0] col_lat_q;
  logic [3:0] dcnt_q;
  logic [3:0] key_code_q;
  logic       key_valid_q;
  logic       key_held_q;

  logic [3:0] dcnt_d;
  logic [3:0] row_d;
  logic [1:0] row_idx_d;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= COL_NONE;
      col_sync_q <= COL_NONE;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
    end
  end

  assign dcnt_d    = dcnt_q + 4'd1;
  assign row_d     = {row_q[2:0], row_q[3]};
  assign row_idx_d = row_idx_q + 2'd1;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned        RPT_W      = $clog2(REPEAT_SCANS + 1);
  localparam logic [RPT_W-1:0]   RPT_LAST   = RPT_W'(REPEAT_SCANS);
  localparam logic [RPT_W-1:0]   RPT_RELOAD = RPT_W'(REPEAT_SCANS - REPEAT_SCANS / 2);
  logic [RPT_W-1:0] rpt_q;
  logic [RPT_W-1:0] rpt_d;
  assign rpt_d = rpt_q + RPT_W'(1);
`endif

  // Row stays parked on the detected row from DEBOUNCE until the release is confirmed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      row_q       <= ROW_FIRST;
      row_idx_q   <= 2'd0;
      col_lat_q   <= COL_NONE;
      dcnt_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (single_low(col_sync_q)) begin
              col_lat_q <= col_sync_q;
              dcnt_q    <= 4'd1;
              state_q   <= DEBOUNCE;
            end else begin
              row_q     <= row_d;
              row_idx_q <= row_idx_d;
            end
          end
          DEBOUNCE: begin
            if (col_sync_q == col_lat_q) begin
              dcnt_q <= dcnt_d;
              if (dcnt_d == DEB_LAST) begin
                key_code_q  <= {row_idx_q, col_index(col_lat_q)};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                state_q     <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                rpt_q       <= '0;
`endif
              end
            end else begin
              state_q   <= SCAN;
              row_q     <= row_d;
              row_idx_q <= row_idx_d;
            end
          end
          PRESSED: begin
            if (col_sync_q == COL_NONE) begin
              dcnt_q  <= 4'd1;
              state_q <= RELEASE;
`ifdef KEYPAD_REPEAT_EN
              rpt_q   <= '0;
`endif
            end else begin
`ifdef KEYPAD_REPEAT_EN
              if (rpt_d == RPT_LAST) begin
                key_valid_q <= 1'b1;
                rpt_q       <= RPT_RELOAD;
              end else begin
                rpt_q <= rpt_d;
              end
`else
              state_q <= PRESSED;
`endif
            end
          end
          RELEASE: begin
            if (col_sync_q == COL_NONE) begin
              dcnt_q <= dcnt_d;
              if (dcnt_d == DEB_LAST) begin
                key_held_q <= 1'b0;
                state_q    <= SCAN;
                row_q      <= row_d;
                row_idx_q  <= row_idx_d;
              end
            end else begin
              state_q <= PRESSED;
            end
          end
          default: begin
            state_q   <= SCAN;
            row_q     <= ROW_FIRST;
            row_idx_q <= 2'd0;
          end
        endcase
      end
    end
  end

  assign row_out   = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad for the safe-box code-entry path.
- It is the input-side counterpart of the LED matrix row-scan driver: it drives one active-low row at a time, samples the active-low column inputs, debounces them and emits a single-cycle key event with a 4-bit key code.
- It feeds the password-compare / lock FSM, which in turn drives the open/locked graphic on the display.

Parameters:
- SCAN_DIV, 62500, clk cycles per scan tick; same divider rate as the display driver (100 Hz at 6.25 MHz).
- DEBOUNCE_SCANS, 4, consecutive identical ticks needed to accept a press or a release; legal range 2..15.
- REPEAT_SCANS, 50, ticks a key must stay held before auto-repeat starts (KEYPAD_REPEAT_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- col_in  in  4  keypad columns, active-low, externally pulled up, asynchronous to clk
- row_out  out  4  keypad row drive, active-low one-hot
- key_code  out  4  code of the last accepted key, {row_idx[1:0], col_idx[1:0]}
- key_valid  out  1  one-clk pulse per accepted key event
- key_held  out  1  high while the accepted key is considered pressed

Behaviour:
- Synchronisation
  - col_in is passed through a 2-flop synchroniser.
  - All decisions use the synchronised value sampled on a tick.
- Tick
  - A 16-bit counter counts 0..SCAN_DIV-1.
  - tick is high for one clk when the count equals SCAN_DIV-1; the counter then wraps to 0.
- Reset values
  - row_out=4'b1110 (row 0).
  - key_code=0, key_valid=0, key_held=0.
  - Counter and debounce count = 0; state = SCAN.
  - A reset mid-operation discards any pending key and emits no pulse.
- Valid pattern: the synchronised columns have exactly one bit low. Zero or two-plus low bits are invalid; invalid covers ghosting and multi-key presses.
- State machine (transitions only on tick, except the key_valid clear):
  - SCAN
    - Valid pattern: latch the row index and the column pattern, set dcnt=1, go to DEBOUNCE. row_out is held.
    - Otherwise: rotate row_out one position (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - DEBOUNCE
    - Pattern equals the latched pattern: dcnt++.
    - When dcnt reaches DEBOUNCE_SCANS: load key_code, set key_valid=1 and key_held=1, go to PRESSED.
    - Pattern differs (including invalid): go to SCAN and rotate the row; no event.
  - PRESSED
    - Columns read all-ones: set dcnt=1 and go to RELEASE.
    - Any other pattern: stay in PRESSED.
  - RELEASE
    - All-ones: dcnt++. When dcnt reaches DEBOUNCE_SCANS: key_held=0, go to SCAN and rotate the row.
    - Any low bit: go back to PRESSED; key_held stays 1 and no new event is raised.
- key_valid
  - Registered, high for exactly one clk.
  - It is asserted the clk after the tick on which dcnt reaches DEBOUNCE_SCANS. Press-to-event latency is therefore DEBOUNCE_SCANS-1 ticks after the first detect tick, plus 1 clk.
- key_code is stable from the key_valid pulse until the next accepted key.
- Exactly one event per press; holding a key never produces a second event (except with the optional feature below).

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter increments on every tick.
  - On reaching REPEAT_SCANS it emits another key_valid with the same key_code and reloads to REPEAT_SCANS/2 below the threshold, giving repeats every REPEAT_SCANS/2 ticks.
  - It clears when the block enters RELEASE.
- Undefined: the repeat counter and its logic are absent; one event per press.

Decomposition:
- Package keypad_pkg holds:
  - the state encoding (SCAN, DEBOUNCE, PRESSED, RELEASE);
  - ROW_IDLE=4'b1111 and COL_NONE=4'b1111;
  - the key-code-to-digit mapping constants used by the lock FSM.
- One natural sub-module: scan_tick_gen (parameter SCAN_DIV; ports clk, rst, tick), reusable by the display driver.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=8):
1. Reset held, then released with no keys: row_out cycles 1110,1101,1011,0111,1110 every 4 clk; key_valid never asserts.
2. Key at row 2, col 1: col_in=4'b1101 only while row_out=1011, held for 20 ticks -> exactly one key_valid pulse with key_code=4'b1001, 2 ticks + 1 clk after the first detect tick. key_held stays 1 until 3 clean all-ones ticks after release.
3. Bounce: col_in toggles between 1101 and 1111 on alternate ticks for 6 ticks, then holds 1101 -> no event during bounce; one event after 3 stable ticks.
4. Two keys on the same row, col_in=4'b1001 -> no key_valid and the row keeps rotating. Releasing to 4'b1101 -> one event.
5. rst asserted during DEBOUNCE (after dcnt=2) -> outputs return to reset values asynchronously; no pulse after deassertion until a fresh 3-tick debounce completes.
6. KEYPAD_REPEAT_EN defined, key held 30 ticks -> initial event, then a repeat at 8 ticks in PRESSED, then every 4 ticks; all repeats carry the same key_code; repeats stop on release.
